// File: rtl/uc_io_sequencer_if.sv
// Peripheral transfer handshake between the io sequencer (master) and the datos-bus peripheral (slave).
interface uc_io_sequencer_if;
    logic io_req;
    logic io_wr;
    logic io_ack;

    modport master (output io_req, output io_wr, input io_ack);
    modport slave  (input io_req, input io_wr, output io_ack);
endinterface

// File: rtl/uc_io_sequencer.sv
// Control unit: decodes opcode/z into datapath selects, stalls PC across IN/OUT handshakes, guards stack depth.
// Optional IO watchdog enabled by defining UC_IO_TIMEOUT_EN.
module uc_io_sequencer #(
    parameter int unsigned STACK_DEPTH = 16
`ifdef UC_IO_TIMEOUT_EN
    , parameter int unsigned IO_TIMEOUT = 255
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 z,
    uc_io_sequencer_if.master    io,
    output logic                 pc_en,
    output logic                 s_inc,
    output logic                 s_stack_mux,
    output logic                 push,
    output logic                 pop,
    output logic                 we3,
    output logic                 wez,
    output logic                 s_mux_alu,
    output logic                 s_inm,
    output logic                 oe,
    output logic [2:0]           op_alu,
    output logic                 stk_ovf,
    output logic                 stk_unf,
    output logic                 io_err
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_CALL = 6'b010011;
    localparam logic [5:0] OP_RET  = 6'b010100;
    localparam logic [5:0] OP_IN   = 6'b011000;
    localparam logic [5:0] OP_OUT  = 6'b011001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IO_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [SP_W-1:0] sp, sp_nxt;
    logic            io_out_q, io_out_nxt;
    logic            stk_ovf_nxt, stk_unf_nxt;

    logic pc_en_c, push_c, pop_c, we3_c, wez_c, oe_c, io_req_c, io_wr_c;

`ifdef UC_IO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(IO_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             io_err_nxt;
`endif

    // State, stack depth and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            sp       <= '0;
            io_out_q <= 1'b0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sp       <= sp_nxt;
            io_out_q <= io_out_nxt;
            stk_ovf  <= stk_ovf_nxt;
            stk_unf  <= stk_unf_nxt;
        end
    end

`ifdef UC_IO_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            io_err <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            io_err <= io_err_nxt;
        end
    end
`else
    assign io_err = 1'b0;
`endif

    // Decode and next-state
    always_comb begin
        state_nxt   = state;
        sp_nxt      = sp;
        io_out_nxt  = io_out_q;
        stk_ovf_nxt = stk_ovf;
        stk_unf_nxt = stk_unf;
        pc_en_c     = 1'b0;
        s_inc       = 1'b1;
        s_stack_mux = 1'b1;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        we3_c       = 1'b0;
        wez_c       = 1'b0;
        s_mux_alu   = 1'b0;
        s_inm       = 1'b0;
        oe_c        = 1'b0;
        op_alu      = 3'b000;
        io_req_c    = 1'b0;
        io_wr_c     = 1'b0;
`ifdef UC_IO_TIMEOUT_EN
        cnt_nxt     = '0;
        io_err_nxt  = io_err;
`endif
        unique case (state)
            RUN: begin
                pc_en_c = 1'b1;
                casez (opcode)
                    6'b000???: begin
                        op_alu    = opcode[2:0];
                        s_mux_alu = 1'b1;
                        we3_c     = 1'b1;
                        wez_c     = 1'b1;
                    end
                    6'b001???: begin
                        op_alu = opcode[2:0];
                        we3_c  = 1'b1;
                        wez_c  = 1'b1;
                    end
                    OP_J:   s_inc = 1'b0;
                    OP_JZ:  s_inc = ~z;
                    OP_JNZ: s_inc = z;
                    OP_CALL: begin
                        s_inc = 1'b0;
                        if (sp == SP_FULL) begin
                            pc_en_c     = 1'b0;
                            stk_ovf_nxt = 1'b1;
                            state_nxt   = HALT;
                        end else begin
                            push_c = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                        end
                    end
                    OP_RET: begin
                        s_stack_mux = 1'b0;
                        if (sp == '0) begin
                            pc_en_c     = 1'b0;
                            stk_unf_nxt = 1'b1;
                            state_nxt   = HALT;
                        end else begin
                            pop_c  = 1'b1;
                            sp_nxt = sp - SP_W'(1);
                        end
                    end
                    OP_IN, OP_OUT: begin
                        pc_en_c    = 1'b0;
                        io_out_nxt = opcode[0];
                        state_nxt  = IO_WAIT;
                    end
                    default: ;
                endcase
            end
            IO_WAIT: begin
                io_req_c = 1'b1;
                io_wr_c  = io_out_q;
                oe_c     = io_out_q;
                // An ack in the timeout cycle still completes normally
                if (io.io_ack) begin
                    pc_en_c   = 1'b1;
                    s_inm     = ~io_out_q;
                    we3_c     = ~io_out_q;
                    state_nxt = RUN;
                end
`ifdef UC_IO_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    pc_en_c    = 1'b1;
                    io_err_nxt = 1'b1;
                    state_nxt  = RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
            HALT: ;
            default: state_nxt = RUN;
        endcase
    end

    // Enables are forced low while reset is held
    assign pc_en     = pc_en_c  & ~reset;
    assign push      = push_c   & ~reset;
    assign pop       = pop_c    & ~reset;
    assign we3       = we3_c    & ~reset;
    assign wez       = wez_c    & ~reset;
    assign oe        = oe_c     & ~reset;
    assign io.io_req = io_req_c & ~reset;
    assign io.io_wr  = io_wr_c;

endmodule

// File: tb/tb_uc_io_sequencer.sv
// Randomized + directed bench for uc_io_sequencer against a cycle-level behavioural model.
module tb_uc_io_sequencer;

    localparam int DEPTH = 16;
`ifdef UC_IO_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 0;
`endif

    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_CALL = 6'b010011;
    localparam logic [5:0] OP_RET  = 6'b010100;
    localparam logic [5:0] OP_IN   = 6'b011000;
    localparam logic [5:0] OP_OUT  = 6'b011001;

    localparam logic [17:0] B_PC   = 18'h20000;
    localparam logic [17:0] B_INC  = 18'h10000;
    localparam logic [17:0] B_STK  = 18'h08000;
    localparam logic [17:0] B_PUSH = 18'h04000;
    localparam logic [17:0] B_POP  = 18'h02000;
    localparam logic [17:0] B_WE3  = 18'h01000;
    localparam logic [17:0] B_WEZ  = 18'h00800;
    localparam logic [17:0] B_MUX  = 18'h00400;
    localparam logic [17:0] B_INM  = 18'h00200;
    localparam logic [17:0] B_OE   = 18'h00100;
    localparam logic [17:0] B_ALU  = 18'h000E0;
    localparam logic [17:0] B_REQ  = 18'h00010;
    localparam logic [17:0] B_WR   = 18'h00008;
    localparam logic [17:0] B_STKY = 18'h00007;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode;
    logic z;
    logic pc_en, s_inc, s_stack_mux, push, pop, we3, wez, s_mux_alu, s_inm, oe;
    logic [2:0] op_alu;
    logic stk_ovf, stk_unf, io_err;

    uc_io_sequencer_if io_bus ();

`ifdef UC_IO_TIMEOUT_EN
    uc_io_sequencer #(.STACK_DEPTH(DEPTH), .IO_TIMEOUT(TMO)) dut (
`else
    uc_io_sequencer #(.STACK_DEPTH(DEPTH)) dut (
`endif
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .io(io_bus),
        .pc_en(pc_en), .s_inc(s_inc), .s_stack_mux(s_stack_mux), .push(push), .pop(pop),
        .we3(we3), .wez(wez), .s_mux_alu(s_mux_alu), .s_inm(s_inm), .oe(oe), .op_alu(op_alu),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf), .io_err(io_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state: what the core is doing, not how the RTL encodes it
    bit m_halt, m_wait, m_out, m_ovf, m_unf, m_err;
    int m_depth, m_wcnt;

    function automatic logic [17:0] observed();
        return {pc_en, s_inc, s_stack_mux, push, pop, we3, wez, s_mux_alu, s_inm, oe,
                op_alu, io_bus.io_req, io_bus.io_wr, stk_ovf, stk_unf, io_err};
    endfunction

    task automatic compare(input string tag, input logic [17:0] exp, input logic [17:0] care);
        logic [17:0] obs;
        obs = observed();
        vectors++;
        assert ((obs & care) === (exp & care)) else begin
            miscompares++;
            $error("FAIL %s observed=%05h expected=%05h care=%05h", tag, obs & care, exp & care, care);
        end
    endtask

    task automatic model(input logic [5:0] op, input logic zz, input logic ack,
                         output logic [17:0] exp, output logic [17:0] care);
        logic pc, inc, stk, pu, po, we, wz, mx, inm, oe_e, req, wr;
        logic [2:0] alu;
        logic [2:0] sticky;
        pc = 0; inc = 1; stk = 1; pu = 0; po = 0; we = 0; wz = 0; mx = 0;
        inm = 0; oe_e = 0; req = 0; wr = 0; alu = 3'b000;
        sticky = {m_ovf, m_unf, m_err};
        care = '1;
        if (m_halt) begin
            care &= ~(B_INC | B_STK | B_MUX | B_INM | B_ALU | B_WR);
        end else if (m_wait) begin
            req = 1; wr = m_out; oe_e = m_out;
            care &= ~(B_STK | B_MUX | B_ALU);
            if (ack) begin
                pc = 1; inm = !m_out; we = !m_out;
                m_wait = 0; m_wcnt = 0;
            end else if (TMO > 0 && m_wcnt + 1 == TMO) begin
                pc = 1; m_err = 1;
                m_wait = 0; m_wcnt = 0;
            end else begin
                m_wcnt++;
                care &= ~B_INC;
            end
        end else begin
            pc = 1;
            care &= ~B_WR;
            if (op[5:4] == 2'b00) begin
                alu = op[2:0]; mx = !op[3]; we = 1; wz = 1;
            end else if (op == OP_J) inc = 0;
            else if (op == OP_JZ) inc = !zz;
            else if (op == OP_JNZ) inc = zz;
            else if (op == OP_CALL) begin
                inc = 0;
                if (m_depth == DEPTH) begin pc = 0; m_ovf = 1; m_halt = 1; end
                else begin pu = 1; m_depth++; end
            end else if (op == OP_RET) begin
                stk = 0;
                if (m_depth == 0) begin pc = 0; m_unf = 1; m_halt = 1; end
                else begin po = 1; m_depth--; end
            end else if (op == OP_IN || op == OP_OUT) begin
                pc = 0; m_wait = 1; m_out = (op == OP_OUT); m_wcnt = 0;
            end
        end
        exp = {pc, inc, stk, pu, po, we, wz, mx, inm, oe_e, alu, req, wr, sticky};
    endtask

    task automatic step(input logic [5:0] op, input logic zz, input logic ack, input string tag);
        logic [17:0] exp, care;
        @(negedge clk);
        opcode = op; z = zz; io_bus.io_ack = ack;
        #1;
        model(op, zz, ack, exp, care);
        compare(tag, exp, care);
        @(posedge clk);
    endtask

    task automatic do_reset(input string tag);
        logic [17:0] rcare;
        rcare = B_PC | B_PUSH | B_POP | B_WE3 | B_WEZ | B_OE | B_REQ | B_STKY;
        @(negedge clk);
        reset = 1'b1;
        opcode = {3'b000, 3'($urandom_range(0, 7))};
        io_bus.io_ack = 1'b1;
        #1;
        m_halt = 0; m_wait = 0; m_out = 0; m_ovf = 0; m_unf = 0; m_err = 0;
        m_depth = 0; m_wcnt = 0;
        compare({tag, "_assert"}, 18'h0, rcare);
        @(posedge clk);
        #1;
        compare({tag, "_hold"}, 18'h0, rcare);
        @(negedge clk);
        io_bus.io_ack = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] specials [9];
        logic [5:0] cur_op;
        specials = '{OP_J, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_IN, OP_OUT, 6'b000101, 6'b001011};
        reset = 1'b1; opcode = 6'b000000; z = 1'b0; io_bus.io_ack = 1'b0;

        do_reset("rst0");

        step(6'b000010, 1'b0, 1'b0, "alu_reg");
        step(6'b001101, 1'b1, 1'b0, "alu_imm");
        step(OP_JZ,  1'b1, 1'b0, "jz_z1");
        step(OP_JZ,  1'b0, 1'b0, "jz_z0");
        step(OP_JNZ, 1'b1, 1'b0, "jnz_z1");
        step(OP_JNZ, 1'b0, 1'b0, "jnz_z0");
        step(OP_J,   1'b0, 1'b1, "jump_ack_ignored");
        step(6'b111010, 1'b0, 1'b0, "nop");

        step(OP_IN, 1'b0, 1'b0, "in_issue");
        step(OP_IN, 1'b0, 1'b0, "in_wait1");
        step(OP_IN, 1'b0, 1'b0, "in_wait2");
        step(OP_IN, 1'b0, 1'b1, "in_ack");
        step(6'b000001, 1'b0, 1'b0, "after_in");
        step(OP_OUT, 1'b0, 1'b0, "out_issue");
        step(OP_OUT, 1'b0, 1'b1, "out_ack_min");

        step(OP_RET, 1'b0, 1'b0, "ret_empty");
        step(6'b000011, 1'b0, 1'b0, "halt_alu");
        step(OP_IN, 1'b0, 1'b1, "halt_in");
        do_reset("rst_unf");
        step(OP_CALL, 1'b0, 1'b0, "call1");
        step(OP_RET,  1'b0, 1'b0, "ret1");

        for (int i = 0; i < DEPTH; i++) step(OP_CALL, 1'b0, 1'b0, "call_fill");
        step(OP_CALL, 1'b0, 1'b0, "call_ovf");
        step(OP_RET, 1'b0, 1'b0, "halt_ret");
        step(OP_J, 1'b0, 1'b0, "halt_j");
        do_reset("rst_ovf");

        step(OP_OUT, 1'b0, 1'b0, "out_rst_issue");
        step(OP_OUT, 1'b0, 1'b0, "out_rst_wait1");
        do_reset("rst_mid_io");
        step(OP_IN, 1'b0, 1'b0, "in_rst_issue");
        step(OP_IN, 1'b0, 1'b0, "in_rst_wait1");
        do_reset("rst_mid_in");

`ifdef UC_IO_TIMEOUT_EN
        step(OP_OUT, 1'b0, 1'b0, "tmo_issue");
        for (int i = 0; i < TMO; i++) step(OP_OUT, 1'b0, 1'b0, "tmo_wait");
        step(6'b000100, 1'b0, 1'b0, "after_tmo");
        step(OP_IN, 1'b0, 1'b0, "race_issue");
        for (int i = 0; i < TMO - 1; i++) step(OP_IN, 1'b0, 1'b0, "race_wait");
        step(OP_IN, 1'b0, 1'b1, "race_ack");
        do_reset("rst_tmo");
`endif

        cur_op = 6'b000000;
        for (int n = 0; n < 700; n++) begin
            if (m_halt && $urandom_range(0, 3) == 0) do_reset("rst_rand");
            if (!m_wait) begin
                if ($urandom_range(0, 1) == 0) cur_op = 6'($urandom_range(0, 63));
                else cur_op = specials[$urandom_range(0, 8)];
            end
            step(cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
